// File: rtl/cv32e40p_illegal_log_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_illegal_log_pkg
// Shared types and helpers for the illegal-instruction recorder.
//   illegal_evt_t : one recorded event {timestamp, hart id, PC}, MSB first.
//   sat_inc       : saturating increment for counters up to SAT_W bits wide.
// ----------------------------------------------------------------------------
package cv32e40p_illegal_log_pkg;

  localparam int unsigned TS_W   = 16;
  localparam int unsigned HART_W = 4;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned SAT_W  = 32;

  // Field order here is the packing order used for the FIFO payload.
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [HART_W-1:0] hart;
    logic [PC_W-1:0]   pc;
  } illegal_evt_t;

  // Increments v unless it already holds the all-ones value of a w-bit counter.
  // Callers zero-extend their counter into SAT_W bits and truncate the result.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned       w);
    logic [SAT_W-1:0] max_v;
    max_v   = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    sat_inc = (v >= max_v) ? v : (v + SAT_W'(1));
  endfunction

endpackage

// File: rtl/cv32e40p_illegal_log_fifo.sv
// ----------------------------------------------------------------------------
// cv32e40p_illegal_log_fifo
// Generic first-word-fall-through FIFO: the head entry is always visible on
// data_o; pop advances to the next entry.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        synchronous flush (same effect as reset)
//   push_i/data_i  write request and payload
//   pop_i          read request (ignored when empty)
//   data_o         head entry (zero when storage has been reset/flushed)
//   full_o/empty_o occupancy flags
//   level_o        registered occupancy, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module cv32e40p_illegal_log_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = pop_i && !w_empty;
  assign w_push  = push_i && (!w_full || w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  assign data_o  = r_mem[r_rptr];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = r_level;

endmodule

// File: rtl/cv32e40p_illegal_insn_recorder.sv
// ----------------------------------------------------------------------------
// cv32e40p_illegal_insn_recorder
// Captures each illegal-instruction event from the core log into a small FWFT
// FIFO as {timestamp, hart id[3:0], PC}, drained through a valid/ready port.
// Debug/simulation state only; nothing feeds back into the pipeline.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clear_i             flush FIFO, counters and overflow (timestamp keeps running)
//   evt_valid_i         one-cycle event flag; evt_pc_i / evt_hart_id_i qualify it
//   rd_valid_o/rd_ready_i  head-entry handshake
//   rd_pc_o/rd_hart_o/rd_time_o  head-entry fields
//   level_o             entries held, 0..DEPTH
//   overflow_o          sticky: an event was dropped
//   total_cnt_o         saturating count of events seen
//   drop_cnt_o          saturating count of events dropped
// Counters are limited to 32 bits by the shared saturating helper.
// ----------------------------------------------------------------------------
module cv32e40p_illegal_insn_recorder
  import cv32e40p_illegal_log_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TS_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 8,
  localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 evt_valid_i,
  input  logic [31:0]          evt_pc_i,
  input  logic [31:0]          evt_hart_id_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [31:0]          rd_pc_o,
  output logic [3:0]           rd_hart_o,
  output logic [TS_WIDTH-1:0]  rd_time_o,
  output logic [LW-1:0]        level_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] total_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
);

  // Payload packed in the same field order as illegal_evt_t.
  localparam int unsigned EVT_W = TS_WIDTH + HART_W + PC_W;

  logic [TS_WIDTH-1:0]  r_ts;
  logic [CNT_WIDTH-1:0] r_total_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic                 r_overflow;

  logic                 w_evt;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [EVT_W-1:0]     w_wdata;
  logic [EVT_W-1:0]     w_rdata;
  logic                 w_unused_hart;

  assign w_unused_hart = ^evt_hart_id_i[31:HART_W];

  // Events in a clear cycle are neither stored nor counted.
  assign w_evt  = evt_valid_i && !clear_i;
  assign w_pop  = !w_empty && rd_ready_i && !clear_i;
  assign w_push = w_evt && (!w_full || w_pop);
  assign w_drop = w_evt && w_full && !w_pop;

  // Gate payload with the push so idle-cycle X never reaches storage.
  assign w_wdata = w_push ? {r_ts, evt_hart_id_i[HART_W-1:0], evt_pc_i} : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_total_cnt <= '0;
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_evt) begin
        r_total_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(r_total_cnt), CNT_WIDTH));
      end
      if (w_drop) begin
        r_drop_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(r_drop_cnt), CNT_WIDTH));
        r_overflow <= 1'b1;
      end
    end
  end

  cv32e40p_illegal_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_wdata),
    .data_o  (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  assign rd_valid_o  = !w_empty;
  assign rd_time_o   = w_rdata[EVT_W-1 -: TS_WIDTH];
  assign rd_hart_o   = w_rdata[PC_W +: HART_W];
  assign rd_pc_o     = w_rdata[PC_W-1:0];
  assign overflow_o  = r_overflow;
  assign total_cnt_o = r_total_cnt;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_cv32e40p_illegal_insn_recorder.sv
module tb_cv32e40p_illegal_insn_recorder;

  localparam int DEPTH = 4;
  localparam int TS_W  = 4;
  localparam int CNT_W = 8;
  localparam int LW    = 3;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              evt_valid;
  logic [31:0]       evt_pc;
  logic [31:0]       evt_hart;
  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_pc;
  logic [3:0]        rd_hart;
  logic [TS_W-1:0]   rd_time;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [CNT_W-1:0]  total_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Spec model of the free-running timestamp.
  logic [TS_W-1:0] m_ts;
  logic [TS_W-1:0] exp_t [5];

  cv32e40p_illegal_insn_recorder #(
    .DEPTH     (DEPTH),
    .TS_WIDTH  (TS_W),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .evt_valid_i   (evt_valid),
    .evt_pc_i      (evt_pc),
    .evt_hart_id_i (evt_hart),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .rd_pc_o       (rd_pc),
    .rd_hart_o     (rd_hart),
    .rd_time_o     (rd_time),
    .level_o       (level),
    .overflow_o    (overflow),
    .total_cnt_o   (total_cnt),
    .drop_cnt_o    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_ts <= '0;
    else     m_ts <= m_ts + 4'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    evt_valid = 1'b0;
    evt_pc    = 'x;
    evt_hart  = 'x;
    clear     = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_ready = 1'b0;
    idle();
    repeat (3) step();
    rst = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rd_valid); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++;
    if (total_cnt !== 8'd0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_counters: got total=%0d drop=%0d want 0/0", total_cnt, drop_cnt);
    end
    checks++;
    if (rd_pc !== 32'd0 || rd_hart !== 4'd0 || rd_time !== 4'd0) begin
      errors++; $display("FAIL reset_data: got pc=%h hart=%h time=%h want 0", rd_pc, rd_hart, rd_time);
    end
  endtask

  task automatic test_basic();
    // Five cycles after reset release the timestamp reads 5.
    repeat (5) step();
    evt_valid = 1'b1;
    evt_pc    = 32'h0000_1A04;
    evt_hart  = 32'hABCD_0003;
    step();
    idle();
    checks++;
    if (rd_valid !== 1'b1 || rd_pc !== 32'h0000_1A04 || rd_hart !== 4'h3 || rd_time !== 4'd5) begin
      errors++;
      $display("FAIL basic_head: got v=%0b pc=%h hart=%h time=%0d want 1/00001a04/3/5",
               rd_valid, rd_pc, rd_hart, rd_time);
    end
    checks++;
    if (level !== 3'd1 || total_cnt !== 8'd1 || overflow !== 1'b0) begin
      errors++; $display("FAIL basic_status: got level=%0d total=%0d ovf=%0b want 1/1/0", level, total_cnt, overflow);
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL basic_drain: got v=%0b level=%0d want 0/0", rd_valid, level);
    end
  endtask

  task automatic test_fill_overflow();
    do_clear();
    checks++;
    if (total_cnt !== 8'd0) begin errors++; $display("FAIL fill_clear_total: got %0d want 0", total_cnt); end
    for (int i = 0; i < 6; i++) begin
      evt_valid = 1'b1;
      evt_pc    = 32'h100 + 32'(4 * i);
      evt_hart  = 32'(i);
      if (i < 4) exp_t[i] = m_ts;
      step();
    end
    idle();
    checks++;
    if (level !== 3'd4 || drop_cnt !== 8'd2 || total_cnt !== 8'd6 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_status: got level=%0d drop=%0d total=%0d ovf=%0b want 4/2/6/1",
               level, drop_cnt, total_cnt, overflow);
    end
    checks++;
    if (rd_pc !== 32'h100 || rd_hart !== 4'd0 || rd_time !== exp_t[0]) begin
      errors++; $display("FAIL fill_head: got pc=%h hart=%h time=%0d want 100/0/%0d", rd_pc, rd_hart, rd_time, exp_t[0]);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_pc [4];
    logic [3:0]  exp_h  [4];
    logic [3:0]  exp_tm [4];
    rd_ready  = 1'b1;
    evt_valid = 1'b1;
    evt_pc    = 32'h200;
    evt_hart  = 32'h7;
    exp_t[4]  = m_ts;
    step();
    idle();
    checks++;
    if (level !== 3'd4 || drop_cnt !== 8'd2 || total_cnt !== 8'd7) begin
      errors++; $display("FAIL fullpp_status: got level=%0d drop=%0d total=%0d want 4/2/7", level, drop_cnt, total_cnt);
    end
    exp_pc = '{32'h104, 32'h108, 32'h10C, 32'h200};
    exp_h  = '{4'd1, 4'd2, 4'd3, 4'd7};
    exp_tm = '{exp_t[1], exp_t[2], exp_t[3], exp_t[4]};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_pc !== exp_pc[k] || rd_hart !== exp_h[k] || rd_time !== exp_tm[k]) begin
        errors++;
        $display("FAIL fullpp_drain%0d: got v=%0b pc=%h hart=%h time=%0d want 1/%h/%h/%0d",
                 k, rd_valid, rd_pc, rd_hart, rd_time, exp_pc[k], exp_h[k], exp_tm[k]);
      end
      step();
    end
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL fullpp_empty: got v=%0b level=%0d want 0/0", rd_valid, level);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] t0;
    rd_ready  = 1'b0;
    t0        = m_ts;
    evt_valid = 1'b1;
    evt_pc    = 32'hA0;
    evt_hart  = 32'h5;
    step();
    evt_pc    = 32'hB0;
    evt_hart  = 32'h9;
    step();
    idle();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'hA0 || rd_hart !== 4'h5 || rd_time !== t0 || level !== 3'd2) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%0b pc=%h hart=%h time=%0d level=%0d want 1/a0/5/%0d/2",
                 c, rd_valid, rd_pc, rd_hart, rd_time, level, t0);
      end
      step();
    end
    rd_ready = 1'b1;
    step();
    checks++;
    if (rd_pc !== 32'hB0 || rd_hart !== 4'h9) begin
      errors++; $display("FAIL bp_second: got pc=%h hart=%h want b0/9", rd_pc, rd_hart);
    end
    step();
    rd_ready = 1'b0;
  endtask

  task automatic test_clear();
    logic [3:0] t_exp;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      evt_valid = 1'b1;
      evt_pc    = 32'h300 + 32'(4 * i);
      evt_hart  = 32'(i);
      step();
    end
    idle();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++;
    if (level !== 3'd3 || overflow !== 1'b1 || total_cnt !== 8'd5 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_pre: got level=%0d ovf=%0b total=%0d drop=%0d want 3/1/5/1",
               level, overflow, total_cnt, drop_cnt);
    end
    // Keep the post-clear timestamp away from zero so a reset counter would show.
    if (m_ts == 4'hF) step();
    clear     = 1'b1;
    evt_valid = 1'b1;
    evt_pc    = 32'h3FC;
    evt_hart  = 32'hE;
    step();
    idle();
    checks++;
    if (level !== 3'd0 || rd_valid !== 1'b0 || total_cnt !== 8'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_post: got level=%0d v=%0b total=%0d drop=%0d ovf=%0b want 0/0/0/0/0",
               level, rd_valid, total_cnt, drop_cnt, overflow);
    end
    t_exp     = m_ts;
    evt_valid = 1'b1;
    evt_pc    = 32'h400;
    evt_hart  = 32'hA;
    step();
    idle();
    checks++;
    if (rd_time !== t_exp || rd_pc !== 32'h400 || total_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_ts_running: got time=%0d pc=%h total=%0d want %0d/400/1", rd_time, rd_pc, total_cnt, t_exp);
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_clear();
    rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      evt_valid = 1'b1;
      evt_pc    = 32'(i);
      evt_hart  = 32'(i);
      step();
    end
    idle();
    checks++;
    if (total_cnt !== 8'd255 || drop_cnt !== 8'd0 || level !== 3'd1 || rd_pc !== 32'd299) begin
      errors++;
      $display("FAIL sat_reader: got total=%0d drop=%0d level=%0d pc=%0d want 255/0/1/299",
               total_cnt, drop_cnt, level, rd_pc);
    end
    step();
    rd_ready = 1'b0;
    do_clear();
    for (int i = 0; i < 300; i++) begin
      evt_valid = 1'b1;
      evt_pc    = 32'(i);
      evt_hart  = 32'(i);
      step();
    end
    idle();
    checks++;
    if (total_cnt !== 8'd255 || drop_cnt !== 8'd255 || level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_drop: got total=%0d drop=%0d level=%0d ovf=%0b want 255/255/4/1",
               total_cnt, drop_cnt, level, overflow);
    end
  endtask

  task automatic test_wrap();
    // FIFO holds stale nonzero entries here; reset must clear the data too.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (level !== 3'd0 || rd_pc !== 32'd0 || total_cnt !== 8'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset: got level=%0d pc=%h total=%0d drop=%0d ovf=%0b want all 0",
               level, rd_pc, total_cnt, drop_cnt, overflow);
    end
    repeat (17) step();
    evt_valid = 1'b1;
    evt_pc    = 32'hCAFE_0010;
    evt_hart  = 32'h1;
    step();
    idle();
    checks++;
    if (rd_time !== 4'd1 || rd_pc !== 32'hCAFE_0010) begin
      errors++; $display("FAIL wrap_time: got time=%0d pc=%h want 1/cafe0010", rd_time, rd_pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_push_pop();
    test_backpressure();
    test_clear();
    test_saturation();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
